fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares one FIFO write port (dout/wren/full) among NUM_REQ requesters using round-robin arbitration.
- Each requester holds the grant for a whole burst. The burst ends on its `last` word or when MAX_BURST words have been accepted.
- Sits between several producer blocks and a single synchronous FIFO. On the FIFO side it drives the same wren/full protocol our FIFO writers use.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 16, maximum words per grant before forced release (1..1024).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- req_last  in  NUM_REQ  marks the final word of requester i's burst.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- dout  out  WIDTH  FIFO write data; registered.
- wren  out  1  FIFO write enable; registered.
- full  in  1  FIFO full flag.
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grantee; registered.
- busy  out  1  high while in BURST state.

Behaviour:
- FIFO commit rule: a word is written at a posedge where wren=1 and full=0. Otherwise wren and dout hold their values (no drop, no change).
- Output register may load when `load_ok = !wren || !full`.
- req_ready[i] = (state==BURST) && (grant_id==i) && load_ok. It is 0 for all other i.
- Requester transfer occurs when req_valid[i] && req_ready[i]. On that edge: dout <= word, wren <= 1.
- If wren && !full and there is no new transfer on that edge: wren <= 0, dout holds.
- Latency: requester transfer to wren asserted is 1 cycle.
- Throughput: 1 word/cycle while full=0.
- State machine:
  - IDLE → BURST when any req_valid is set. The round-robin pick searches from (last_grant+1) mod NUM_REQ upward. On this edge grant_id <= winner and beat_cnt <= 0.
  - BURST: each transfer increments beat_cnt.
  - BURST → IDLE on a transfer with req_last[grant_id]=1, or on the transfer that makes beat_cnt reach MAX_BURST. On this edge last_grant <= grant_id.
  - IDLE always costs one bubble cycle between grants, so no requester is ready in IDLE.
- The grantee deasserting req_valid mid-burst does not release the grant. Grant persists until last or MAX_BURST.
- Non-granted requesters' valid/data/last are ignored. Requesters must hold data stable while valid && !ready.
- A burst with only req_last set on its first word is a 1-word grant.
- MAX_BURST=1 releases after every word.
- beat_cnt width is clog2(MAX_BURST+1). Terminal compare is beat_cnt+1 == MAX_BURST.
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, wren=0, dout=0, grant_id=0, beat_cnt=0, busy=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-burst: a pending uncommitted word in the output register is discarded. The FIFO sees wren=0 immediately (asynchronously).
- Simultaneous events:
  - A commit and a new transfer on the same edge: wren stays 1 and dout takes the new word.
  - Release and a new request on the same edge: the new grant waits for the IDLE cycle.
- full asserted while in IDLE: the current output word waits. Arbitration still proceeds, but req_ready stays 0 until load_ok.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - a clog2 function for the grant_id and beat_cnt widths.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Reusable by other arbiters.

Test Plan:
- Single requester 2, 3-word burst (0xA1,0xA2,0xA3 with last on 0xA3), full=0 → grant_id=2; wren high 3 consecutive cycles starting 1 cycle after first accept; dout sequence A1,A2,A3; busy drops after third accept.
- All 4 requesting continuously, 1-word bursts (last=1), from reset → grant order 0,1,2,3,0; one IDLE bubble between grants.
- Requester 1 streams 20 words with no last, MAX_BURST=16 → exactly 16 words accepted; grant passes to next valid requester (3 if requesting); requester 1 regains the grant later and sends words 17–20.
- full held high 5 cycles while wren=1 with dout=0x55 → wren and dout hold, req_ready=0; word 0x55 commits on first edge with full=0; no duplicate, no loss.
- Grantee 0 drops valid for 4 cycles mid-burst while requester 3 is valid → grant stays 0, req_ready[3]=0; burst resumes and completes on last.
- Assert rst_n=0 mid-burst with wren=1, full=1 → wren=0 immediately; after release: IDLE, grant_id=0, requester 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, searching upward from last_grant+1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [IW-1:0] o_winner,
    output logic          o_any_req
);

    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_winner = i_last_grant;
        w_idx    = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IW'((int'(i_last_grant) + k) % N);
            o_winner = i_req[w_idx] ? w_idx : o_winner;
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port
// among NUM_REQ producers; grant held until last word or MAX_BURST words.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       wren,
    input  logic                       full,
    output logic [clog2(NUM_REQ)-1:0]  grant_id,
    output logic                       busy
);

    localparam int GW = clog2(NUM_REQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_dout;
    logic            r_wren;
    logic [GW-1:0]   r_grant, r_last_grant, w_winner;
    logic [BW-1:0]   r_beat;
    logic            w_any, w_load_ok, w_xfer, w_term;

    rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
        .i_req       (req_valid),
        .i_last_grant(r_last_grant),
        .o_winner    (w_winner),
        .o_any_req   (w_any)
    );

    // The output register is free unless it holds a word the FIFO is refusing.
    assign w_load_ok = !r_wren || !full;
    assign w_xfer    = |(req_valid & req_ready);
    assign w_term    = req_last[r_grant] || (r_beat + BW'(1) == MAXB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_any ? BURST : IDLE)
                                   : ((w_xfer && w_term) ? IDLE : BURST);
    end

    always_comb begin
        busy      = (r_state == BURST);
        req_ready = (busy && w_load_ok) ? (NUM_REQ'(1) << r_grant) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_wren       <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_beat       <= '0;
        end else begin
            if (w_xfer) begin
                r_dout <= req_data[r_grant*WIDTH +: WIDTH];
                r_wren <= 1'b1;
            end else if (!full) begin
                r_wren <= 1'b0;
            end
            if (r_state == IDLE && w_any) begin
                r_grant <= w_winner;
                r_beat  <= '0;
            end
            if (r_state == BURST && w_xfer) begin
                r_beat <= r_beat + BW'(1);
                if (w_term) r_last_grant <= r_grant;
            end
        end
    end

    assign dout     = r_dout;
    assign wren     = r_wren;
    assign grant_id = r_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed bursts with a commit-side scoreboard
// holding {grant_id, data} for every word the FIFO should receive.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  dout;
    logic        wren;
    logic        full = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          commit_cyc[$];

    fifo_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .dout(dout), .wren(wren),
        .full(full), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs only change at posedge+1, so wren && !full here means a commit on the next edge.
    always @(negedge clk) begin
        if (rst_n && wren && !full) begin
            commit_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_commit", {22'b0, grant_id, dout}, 32'hFFFF_FFFF);
            else chk("commit", {22'b0, grant_id, dout}, {16'b0, exp_q.pop_front()});
        end
    end

    task automatic expect_word(input int id, input logic [7:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic l);
        int n;
        n = 0;
        req_valid[id] = 1'b1;
        req_data[id*8 +: 8] = d;
        req_last[id] = l;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 200);
        if (!req_ready[id]) begin
            n_total++;
            $display("FAIL send_timeout: requester %0d word %0h never ready", id, d);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        full = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        chk("rst_wren", wren, 0);
        chk("rst_dout", dout, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);

        // single requester 2, three-word burst
        commit_cyc.delete();
        expect_word(2, 8'hA1); expect_word(2, 8'hA2); expect_word(2, 8'hA3);
        send(2, 8'hA1, 1'b0);
        chk("t1_lat_wren", wren, 1);
        chk("t1_lat_dout", dout, 8'hA1);
        chk("t1_grant", grant_id, 2);
        chk("t1_busy", busy, 1);
        send(2, 8'hA2, 1'b0);
        send(2, 8'hA3, 1'b1);
        chk("t1_busy_drop", busy, 0);
        chk("t1_last_dout", dout, 8'hA3);
        drain("t1_drain");
        chk("t1_ncommit", commit_cyc.size(), 3);
        for (int i = 1; i < commit_cyc.size(); i++) chk("t1_b2b", commit_cyc[i] - commit_cyc[i-1], 1);

        // all four requesting one-word bursts
        do_reset();
        commit_cyc.delete();
        expect_word(0, 8'h10); expect_word(1, 8'h11); expect_word(2, 8'h12);
        expect_word(3, 8'h13); expect_word(0, 8'h14);
        fork
            begin send(0, 8'h10, 1'b1); send(0, 8'h14, 1'b1); end
            send(1, 8'h11, 1'b1);
            send(2, 8'h12, 1'b1);
            send(3, 8'h13, 1'b1);
        join
        drain("t2_drain");
        chk("t2_ncommit", commit_cyc.size(), 5);
        for (int i = 1; i < commit_cyc.size(); i++) chk("t2_bubble", commit_cyc[i] - commit_cyc[i-1], 2);

        // requester 1 streams 20 words, forced release at 16
        do_reset();
        commit_cyc.delete();
        for (int k = 0; k < 16; k++) expect_word(1, 8'(8'h20 + k));
        expect_word(3, 8'h3F);
        for (int k = 16; k < 20; k++) expect_word(1, 8'(8'h20 + k));
        fork
            for (int k = 0; k < 20; k++) send(1, 8'(8'h20 + k), k == 19);
            send(3, 8'h3F, 1'b1);
        join
        drain("t3_drain");
        chk("t3_ncommit", commit_cyc.size(), 21);

        // full stalls the output register
        do_reset();
        expect_word(0, 8'h55); expect_word(0, 8'h56);
        send(0, 8'h55, 1'b0);
        full = 1'b1;
        fork
            send(0, 8'h56, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_hold_wren", wren, 1);
                    chk("t4_hold_dout", dout, 8'h55);
                    chk("t4_ready", req_ready, 0);
                end
                @(posedge clk);
                #1;
                full = 1'b0;
            end
        join
        drain("t4_drain");

        // grantee drops valid mid-burst while requester 3 waits
        do_reset();
        expect_word(0, 8'h60); expect_word(0, 8'h61); expect_word(0, 8'h62); expect_word(3, 8'h70);
        fork
            begin
                send(0, 8'h60, 1'b0);
                repeat (4) begin
                    @(negedge clk);
                    chk("t5_grant", grant_id, 0);
                    chk("t5_ready3", req_ready[3], 0);
                    chk("t5_busy", busy, 1);
                end
                @(posedge clk);
                #1;
                send(0, 8'h61, 1'b0);
                send(0, 8'h62, 1'b1);
            end
            send(3, 8'h70, 1'b1);
        join
        drain("t5_drain");

        // reset mid-burst discards the pending word
        do_reset();
        expect_word(1, 8'h7E);
        send(1, 8'h7E, 1'b1);
        drain("t6_pre_drain");
        send(2, 8'h80, 1'b0);
        chk("t6_pre_grant", grant_id, 2);
        full = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_wren", wren, 0);
        chk("t6_async_busy", busy, 0);
        full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_grant", grant_id, 0);
        chk("t6_post_busy", busy, 0);
        expect_word(0, 8'h81); expect_word(2, 8'h82);
        fork
            send(0, 8'h81, 1'b1);
            send(2, 8'h82, 1'b1);
        join
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
